// File: rtl/interrupt_controller.sv
// Interrupt controller: synchronizes IRQ pins, composes mip, arbitrates and sequences delivery to execute.
// Define SUPERVISOR_IRQ_EN to add S-level sources (SEIP/STIP/SSIP) and mideleg-based delegation.
module interrupt_controller #(
  parameter int XLEN        = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ext_irq_m,
  input  logic            ext_irq_s,
  input  logic            timer_irq,
  input  logic [XLEN-1:0] mip_sw,
  input  logic [XLEN-1:0] mie,
  input  logic [XLEN-1:0] mstatus,
  input  logic [XLEN-1:0] mideleg,
  input  logic [1:0]      privilege_mode,
  input  logic            exec_boundary,
  input  logic            exec_system_blocked_on_wfi,
  input  logic            exec_system_will_do_xret,
  input  logic            trap_ack,
  output logic [XLEN-1:0] mip,
  output logic            exec_interrupt,
  output logic [3:0]      interrupt_cause,
  output logic            interrupt_to_smode,
  output logic            wfi_wake
);

  typedef enum logic [1:0] {IDLE, ARMED, REQ, HOLDOFF} state_t;
  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sync_m, sync_s, sync_t;
  logic [XLEN-1:0]        mip_next, pend, enabled, deleg;
  logic                   m_en, win_valid, win_smode, boundary_open;
  logic [3:0]             win_cause, cause_q;
  logic                   smode_q;
  logic                   unused;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_m   <= '0;
      sync_s   <= '0;
      sync_t   <= '0;
      mip      <= '0;
      wfi_wake <= 1'b0;
    end else begin
      sync_m   <= {sync_m[SYNC_STAGES-2:0], ext_irq_m};
      sync_s   <= {sync_s[SYNC_STAGES-2:0], ext_irq_s};
      sync_t   <= {sync_t[SYNC_STAGES-2:0], timer_irq};
      mip      <= mip_next;
      wfi_wake <= |(mip & mie);
    end
  end

  always_comb begin
    mip_next     = '0;
    mip_next[11] = sync_m[SYNC_STAGES-1];
    mip_next[7]  = sync_t[SYNC_STAGES-1];
    mip_next[3]  = mip_sw[3];
`ifdef SUPERVISOR_IRQ_EN
    mip_next[9]  = mip_sw[9] | sync_s[SYNC_STAGES-1];
    mip_next[5]  = mip_sw[5];
    mip_next[1]  = mip_sw[1];
`endif
  end

  assign pend = mip & mie;
  assign m_en = (privilege_mode != 2'b11) || mstatus[3];

`ifdef SUPERVISOR_IRQ_EN
  logic s_en;
  assign s_en    = (privilege_mode == 2'b00) || ((privilege_mode == 2'b01) && mstatus[1]);
  assign deleg   = mideleg;
  assign enabled = (pend & ~deleg & {XLEN{m_en}}) | (pend & deleg & {XLEN{s_en}});
`else
  assign deleg   = '0;
  assign enabled = pend & {XLEN{m_en}};
`endif

  // Fixed priority: MEI, MSI, MTI, SEI, SSI, STI.
  always_comb begin
    win_valid = 1'b1;
    win_cause = 4'd0;
    win_smode = 1'b0;
    if (enabled[11]) begin
      win_cause = 4'd11; win_smode = deleg[11];
    end else if (enabled[3]) begin
      win_cause = 4'd3;  win_smode = deleg[3];
    end else if (enabled[7]) begin
      win_cause = 4'd7;  win_smode = deleg[7];
    end else if (enabled[9]) begin
      win_cause = 4'd9;  win_smode = deleg[9];
    end else if (enabled[1]) begin
      win_cause = 4'd1;  win_smode = deleg[1];
    end else if (enabled[5]) begin
      win_cause = 4'd5;  win_smode = deleg[5];
    end else begin
      win_valid = 1'b0;
    end
  end

  assign boundary_open = (exec_boundary | exec_system_blocked_on_wfi) & ~exec_system_will_do_xret;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (win_valid) state_next = ARMED;
      ARMED: begin
        if (!win_valid)         state_next = IDLE;
        else if (boundary_open) state_next = REQ;
      end
      REQ:     if (trap_ack) state_next = HOLDOFF;
      HOLDOFF: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    exec_interrupt     = (state == REQ);
    interrupt_cause    = cause_q;
    interrupt_to_smode = smode_q;
  end

  // Cause and target track arbitration until REQ, then stay frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      cause_q <= 4'd0;
      smode_q <= 1'b0;
    end else if (((state == IDLE) || (state == ARMED)) && win_valid) begin
      cause_q <= win_cause;
      smode_q <= win_smode;
    end
  end

  assign unused = ^{mip_sw, mstatus, mideleg, sync_s, deleg};

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios plus a cycle-level reference model checked every cycle.
// Build with SUPERVISOR_IRQ_EN defined to also exercise delegation.
module tb_interrupt_controller;
  localparam int XLEN = 32;
  localparam int SYNC_STAGES = 2;
  localparam int ORDER [6] = '{11, 3, 7, 9, 1, 5};

  logic            clk = 1'b0;
  logic            rst;
  logic            ext_irq_m, ext_irq_s, timer_irq;
  logic [XLEN-1:0] mip_sw, mie, mstatus, mideleg;
  logic [1:0]      privilege_mode;
  logic            exec_boundary, exec_system_blocked_on_wfi, exec_system_will_do_xret, trap_ack;
  logic [XLEN-1:0] mip;
  logic            exec_interrupt;
  logic [3:0]      interrupt_cause;
  logic            interrupt_to_smode;
  logic            wfi_wake;

  interrupt_controller #(.XLEN(XLEN), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst),
    .ext_irq_m(ext_irq_m), .ext_irq_s(ext_irq_s), .timer_irq(timer_irq),
    .mip_sw(mip_sw), .mie(mie), .mstatus(mstatus), .mideleg(mideleg),
    .privilege_mode(privilege_mode),
    .exec_boundary(exec_boundary),
    .exec_system_blocked_on_wfi(exec_system_blocked_on_wfi),
    .exec_system_will_do_xret(exec_system_will_do_xret),
    .trap_ack(trap_ack),
    .mip(mip), .exec_interrupt(exec_interrupt), .interrupt_cause(interrupt_cause),
    .interrupt_to_smode(interrupt_to_smode), .wfi_wake(wfi_wake)
  );

  always #5 clk = ~clk;

`ifdef SUPERVISOR_IRQ_EN
  localparam bit SUP = 1'b1;
`else
  localparam bit SUP = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Reference model: pin history as a delay line, phase 0=waiting 1=armed 2=requesting 3=holdoff.
  logic [2:0]      hist [$];
  logic [XLEN-1:0] m_mip;
  int              m_phase;
  int              m_cause;
  logic            m_smode, m_wake, m_started = 1'b0;

  function automatic logic [XLEN-1:0] compose(input logic [2:0] pins, input logic [XLEN-1:0] sw);
    logic [XLEN-1:0] r = '0;
    r[11] = pins[2];
    r[7]  = pins[0];
    r[3]  = sw[3];
    if (SUP) begin
      r[9] = sw[9] | pins[1];
      r[5] = sw[5];
      r[1] = sw[1];
    end
    return r;
  endfunction

  function automatic void pick(input logic [XLEN-1:0] mv, output logic found,
                               output int code, output logic dl);
    found = 1'b0; code = 0; dl = 1'b0;
    for (int k = 0; k < 6; k++) begin
      int  b = ORDER[k];
      bit  d = SUP && mideleg[b];
      bit  en;
      if (d) en = (privilege_mode == 2'd0) || (privilege_mode == 2'd1 && mstatus[1]);
      else   en = (privilege_mode < 2'd3) || mstatus[3];
      if (!found && mv[b] && mie[b] && en) begin
        found = 1'b1; code = b; dl = d;
      end
    end
  endfunction

  always @(posedge clk) begin
    logic f, dl;
    int   c;
    logic [2:0] oldest;
    if (rst) begin
      hist.delete();
      for (int i = 0; i < SYNC_STAGES; i++) hist.push_back(3'b000);
      m_mip = '0; m_phase = 0; m_cause = 0; m_smode = 1'b0; m_wake = 1'b0;
    end else begin
      pick(m_mip, f, c, dl);
      m_wake = |(m_mip & mie);
      case (m_phase)
        0: if (f) begin m_phase = 1; m_cause = c; m_smode = dl; end
        1: if (!f) m_phase = 0;
           else begin
             m_cause = c; m_smode = dl;
             if ((exec_boundary || exec_system_blocked_on_wfi) && !exec_system_will_do_xret) m_phase = 2;
           end
        2: if (trap_ack) m_phase = 3;
        default: m_phase = 0;
      endcase
      oldest = hist.pop_front();
      m_mip  = compose(oldest, mip_sw);
      hist.push_back({ext_irq_m, ext_irq_s, timer_irq});
    end
    m_started = 1'b1;
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("model mip", mip, m_mip);
      chk("model exec_interrupt", exec_interrupt, (m_phase == 2));
      chk("model wfi_wake", wfi_wake, m_wake);
      if (m_phase == 2) begin
        chk("model cause", interrupt_cause, m_cause);
        chk("model to_smode", interrupt_to_smode, m_smode);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int max, input string name);
    int k = 0;
    while (exec_interrupt !== 1'b1 && k < max) begin
      step(1);
      k++;
    end
    chk(name, exec_interrupt, 1);
  endtask

  task automatic ack_clear();
    trap_ack = 1'b1; mie = '0; mip_sw = '0;
    ext_irq_m = 1'b0; ext_irq_s = 1'b0; timer_irq = 1'b0;
    exec_system_blocked_on_wfi = 1'b0;
    step(1);
    trap_ack = 1'b0;
    chk("drop after ack", exec_interrupt, 0);
    step(5);
  endtask

  initial begin
    rst = 1'b1;
    ext_irq_m = 0; ext_irq_s = 0; timer_irq = 0;
    mip_sw = '0; mie = '0; mstatus = '0; mideleg = '0; privilege_mode = 2'd3;
    exec_boundary = 0; exec_system_blocked_on_wfi = 0; exec_system_will_do_xret = 0; trap_ack = 0;
    step(2);
    chk("reset mip", mip, 0);
    chk("reset exec", exec_interrupt, 0);
    chk("reset cause", interrupt_cause, 0);
    chk("reset smode", interrupt_to_smode, 0);
    chk("reset wake", wfi_wake, 0);
    rst = 1'b0;

    // Timer: pin to request in SYNC_STAGES+3 edges, ack three cycles later.
    mstatus = 32'h8; mie = 32'h80; exec_boundary = 1; timer_irq = 1;
    step(4);
    chk("timer mip", mip, 32'h80);
    chk("timer not yet", exec_interrupt, 0);
    step(1);
    chk("timer req", exec_interrupt, 1);
    chk("timer cause", interrupt_cause, 7);
    step(3);
    chk("timer held", exec_interrupt, 1);
    ack_clear();

    // MEI beats MSI; MSI follows after holdoff.
    mie = 32'h808; exec_boundary = 0; mip_sw = 32'h8; ext_irq_m = 1;
    step(5);
    exec_boundary = 1;
    step(1);
    chk("mei req", exec_interrupt, 1);
    chk("mei cause", interrupt_cause, 11);
    trap_ack = 1; ext_irq_m = 0;
    step(1);
    trap_ack = 0;
    chk("mei holdoff", exec_interrupt, 0);
    wait_req(10, "msi second req");
    chk("msi cause", interrupt_cause, 3);
    ack_clear();

    // MSI beats MTI.
    mie = 32'h88; exec_boundary = 0; mip_sw = 32'h8; timer_irq = 1;
    step(5);
    exec_boundary = 1;
    step(1);
    chk("msi over mti", interrupt_cause, 3);
    ack_clear();

    // Boundary closed, stray ack ignored, WFI opens it; xRET delays by one cycle.
    mie = 32'h8; mip_sw = 32'h8; exec_boundary = 0;
    step(2);
    trap_ack = 1;
    step(1);
    trap_ack = 0;
    step(3);
    chk("closed boundary", exec_interrupt, 0);
    exec_system_blocked_on_wfi = 1;
    step(1);
    chk("wfi req", exec_interrupt, 1);
    exec_system_blocked_on_wfi = 0; trap_ack = 1;
    step(1);
    trap_ack = 0;
    step(2);
    exec_system_blocked_on_wfi = 1; exec_system_will_do_xret = 1;
    step(1);
    chk("xret blocks", exec_interrupt, 0);
    exec_system_will_do_xret = 0;
    step(1);
    chk("after xret", exec_interrupt, 1);
    ack_clear();

    // MIE=0 in M-mode: wake only; dropping to U-mode delivers.
    mstatus = 32'h0; mie = 32'h800; ext_irq_m = 1; exec_boundary = 1;
    step(4);
    chk("wake no mie", wfi_wake, 1);
    step(3);
    chk("masked in M", exec_interrupt, 0);
    privilege_mode = 2'd0;
    step(2);
    chk("U-mode req", exec_interrupt, 1);
    chk("U-mode cause", interrupt_cause, 11);
    privilege_mode = 2'd3; mstatus = 32'h8;
    ack_clear();

    // Pending clears in ARMED vs in REQ.
    mie = 32'h8; mip_sw = 32'h8; exec_boundary = 0;
    step(2);
    mip_sw = 32'h0;
    step(5);
    chk("armed withdraw", exec_interrupt, 0);
    mip_sw = 32'h8;
    step(2);
    exec_boundary = 1;
    step(1);
    chk("req entered", exec_interrupt, 1);
    mip_sw = 32'h0; exec_boundary = 0;
    step(3);
    chk("req held", exec_interrupt, 1);
    ack_clear();

    // Reset in REQ drops the request.
    mie = 32'h8; mip_sw = 32'h8; exec_boundary = 1;
    step(3);
    chk("pre-reset req", exec_interrupt, 1);
    rst = 1; mip_sw = '0;
    step(1);
    chk("reset exec drop", exec_interrupt, 0);
    chk("reset mip drop", mip, 0);
    rst = 0; mip_sw = 32'h8;
    step(1);
    chk("idle after reset", exec_interrupt, 0);
    mie = '0; mip_sw = '0;
    step(4);

    // S-level software bits only exist with delegation support.
    mip_sw = 32'hFFFF_FFFF;
    step(1);
    chk("mip compose", mip, SUP ? 32'h22A : 32'h8);
    mip_sw = '0;
    step(3);

`ifdef SUPERVISOR_IRQ_EN
    privilege_mode = 2'd1; mstatus = 32'h2; mideleg = 32'h200; mie = 32'h200;
    ext_irq_s = 1; exec_boundary = 1;
    wait_req(10, "sei req");
    chk("sei cause", interrupt_cause, 9);
    chk("sei smode", interrupt_to_smode, 1);
    trap_ack = 1; privilege_mode = 2'd3; mstatus = 32'h8;
    step(1);
    trap_ack = 0;
    step(8);
    chk("sei masked in M", exec_interrupt, 0);
    mideleg = '0;
    ack_clear();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Arbitrates pending machine- and supervisor-level interrupts and sequences their delivery into the execute stage. Synchronizes external and timer interrupt lines, composes `mip`, selects the highest-priority enabled interrupt, and raises `exec_interrupt` only at a safe instruction boundary. `exec_interrupt` also wakes a blocked WFI in the system unit. Holds the request until the trap unit acknowledges trap entry.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on asynchronous interrupt pins; legal range 2..4.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `ext_irq_m`, `ext_irq_s`, `timer_irq`  in  1 each  asynchronous level interrupt lines.
- `mip_sw`  in  XLEN  software-writable `mip` bits, taken from the CSR file. Only bits 1, 3, 5 and 9 are used.
- `mie`, `mstatus`  in  XLEN  current CSR values.
- `mideleg`  in  XLEN  delegation mask; used only with `SUPERVISOR_IRQ_EN`.
- `privilege_mode`  in  2  current privilege level.
- `exec_boundary`  in  1  no instruction will commit in execute this cycle.
- `exec_system_blocked_on_wfi`  in  1  system unit is stalled on WFI.
- `exec_system_will_do_xret`  in  1  an xRET commits this cycle.
- `trap_ack`  in  1  trap unit has taken the current interrupt.
- `mip`  out  XLEN  registered composed `mip`.
- `exec_interrupt`  out  1  interrupt request to execute/system units.
- `interrupt_cause`  out  4  exception code of the requested interrupt.
- `interrupt_to_smode`  out  1  trap targets S-mode.
- `wfi_wake`  out  1  registered; some `mip & mie` bit is set, ignoring global enables.

## Operation
- **Synchronizers:** each pin passes through `SYNC_STAGES` flops.
- **`mip` composition** (registered):
  - bit 11 (MEIP) = synchronized `ext_irq_m`.
  - bit 7 (MTIP) = synchronized `timer_irq`.
  - bit 3 (MSIP) = `mip_sw[3]`.
  - bit 9 (SEIP) = `mip_sw[9]` | synchronized `ext_irq_s`.
  - bits 5 and 1 (STIP, SSIP) = `mip_sw` bits 5 and 1.
  - All other bits are 0.
- **Pending set:** `pend = mip & mie`.
- **M-level enable:** a pending bit is enabled if `privilege_mode` < M, or if `privilege_mode` = M and `mstatus.MIE` (bit 3) is set.
- **Priority** (highest first): 11, 3, 7, 9, 1, 5. `interrupt_cause` is the winning bit number.
- **FSM states:**
  - IDLE: when any enabled pending bit exists, latch its cause and go to ARMED.
  - ARMED:
    - Re-arbitrate every cycle and update the cause.
    - If no enabled pending bit remains, go to IDLE.
    - If (`exec_boundary` | `exec_system_blocked_on_wfi`) and not `exec_system_will_do_xret`, go to REQ.
  - REQ:
    - `exec_interrupt` = 1. Cause and target are frozen.
    - Stay in REQ even if the pending bit clears.
    - On `trap_ack`, go to HOLDOFF.
  - HOLDOFF: one cycle so the trap-entry `mstatus`/`privilege_mode` update is visible, then IDLE.
- **Simultaneous events:**
  - `trap_ack` outside REQ is ignored.
  - A new higher-priority interrupt arriving during REQ does not pre-empt; it is taken after HOLDOFF.
- **Reset values:** state IDLE; `mip`, synchronizers, `exec_interrupt`, `interrupt_cause`, `interrupt_to_smode` and `wfi_wake` all 0. Reset mid-REQ drops the request with no ack required.

## Timing
- A pin sampled at edge 1 appears in `mip` at edge `SYNC_STAGES`+1.
- From `mip` update, ARMED is reached 1 edge later. REQ (`exec_interrupt` high) follows 1 further edge if the boundary is open.
- Total pin-to-`exec_interrupt` latency: `SYNC_STAGES`+3 edges.
- `mip_sw` changes reach `mip` 1 edge later.
- `exec_interrupt` stays high from REQ entry through the `trap_ack` cycle. It is low the next cycle (HOLDOFF).
- Minimum spacing between two requests: 1 HOLDOFF cycle plus 1 IDLE→ARMED cycle.
- `wfi_wake` lags `mip`/`mie` by 1 edge.

## Configuration
- **`SUPERVISOR_IRQ_EN` defined:**
  - Delegated bits (`mideleg` bit set) are enabled only if `privilege_mode` = U, or if it is S and `mstatus.SIE` (bit 1) is set.
  - Delegated bits are never enabled in M-mode.
  - `interrupt_to_smode` = 1 when the winner is delegated.
  - Priority order is unchanged.
- **Undefined:**
  - `mideleg` is ignored, and `interrupt_to_smode` is constant 0.
  - Bits 9, 5 and 1 read 0 in `mip` and never fire; only M-level sources are arbitrated.

## Test plan
- M-mode, `mstatus.MIE`=1, `mie[7]`=1, `exec_boundary`=1; raise `timer_irq` → `exec_interrupt` high 5 edges later (`SYNC_STAGES`=2) with cause 7. Hold `trap_ack` 3 cycles later → `exec_interrupt` drops the next cycle.
- `mip_sw[3]` and `ext_irq_m` pending together with both enabled → cause 11. After ack and HOLDOFF, with MIE still 1 → second request with cause 3.
- In ARMED, hold `exec_boundary`=0 for 4 cycles, then assert `exec_system_blocked_on_wfi` → REQ on the next edge. Repeat with `exec_system_will_do_xret`=1 in that cycle → REQ is delayed by 1 cycle.
- M-mode with MIE=0, `mie[11]`=1, `ext_irq_m`=1 → `wfi_wake`=1, `exec_interrupt` stays 0. Switch `privilege_mode` to U → request with cause 11.
- In ARMED, clear `mip_sw[3]` → return to IDLE with no request. In REQ, clear it → request held until `trap_ack`.
- Assert `rst` while in REQ → `exec_interrupt` and `mip` are 0 on the next edge, and state is IDLE.
- With `SUPERVISOR_IRQ_EN`: S-mode, SIE=1, `mideleg[9]`=1, `ext_irq_s`=1 → cause 9 with `interrupt_to_smode`=1. The same stimulus in M-mode produces no request.
